// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames the UART receive byte stream into command packets
//   SYNC, CMD, LEN, payload[LEN], CHK
// Payload bytes stream out on a write port. Accepted frames pulse cmd_valid and
// rejected frames pulse err_valid. The checksum is the XOR of CMD, LEN and the
// payload bytes.
// Optional feature: define UART_CMD_PARSER_TIMEOUT_EN to abort a frame when the
// gap between bytes inside the frame reaches TIMEOUT_CYCLES clk_in cycles.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          MAX_LEN        = 16,
  parameter int          ADDR_W         = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd43400
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_done,
  output logic              pl_wr_en,
  output logic [ADDR_W-1:0] pl_wr_addr,
  output logic [7:0]        pl_wr_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic [7:0]        cmd_len,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              frame_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  // One bit wider than the address so that MAX_LEN == 2**ADDR_W cannot wrap
  // before the last-byte compare.
  localparam int IW = ADDR_W + 1;

  logic [2:0]    state, state_d;
  logic [7:0]    csum, cmd_sh, len_sh;
  logic [IW-1:0] idx;
  logic          tmo_hit;
  logic          len_bad, len_zero, pay_last, chk_ok;

  assign len_bad  = 32'(uart_rx_data) > 32'(MAX_LEN);
  assign len_zero = uart_rx_data == 8'd0;
  assign pay_last = (32'(idx) + 32'd1) == 32'(len_sh);
  assign chk_ok   = uart_rx_data == csum;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Inter-byte gap counter. It runs only inside a frame and restarts on every byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                              tmo_cnt <= 32'd0;
    else if (state == S_IDLE || uart_rx_done) tmo_cnt <= 32'd0;
    else                                     tmo_cnt <= tmo_cnt + 32'd1;
  end

  // Fires on the cycle the gap count would reach TIMEOUT_CYCLES. A byte arriving
  // on that same cycle takes priority over the timeout.
  assign tmo_hit = (state != S_IDLE) && !uart_rx_done &&
                   (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  // The timeout is disabled, so this term never fires. The parameter stays in the
  // list so that both builds are drop-in compatible.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

  // Next-state decode. Bytes advance the frame. A timeout returns to IDLE.
  always_comb begin
    state_d = state;
    if (uart_rx_done) begin
      case (state)
        S_IDLE:  if (uart_rx_data == SYNC_BYTE) state_d = S_CMD;
        S_CMD:   state_d = S_LEN;
        S_LEN:   state_d = len_bad ? S_IDLE : (len_zero ? S_CHK : S_PAY);
        S_PAY:   if (pay_last) state_d = S_CHK;
        S_CHK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

  // Frame datapath and registered outputs. Strobes default low so that each
  // one lasts exactly one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      frame_busy <= 1'b0;
      csum       <= 8'd0;
      cmd_sh     <= 8'd0;
      len_sh     <= 8'd0;
      idx        <= '0;
      pl_wr_en   <= 1'b0;
      pl_wr_addr <= '0;
      pl_wr_data <= 8'd0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'd0;
      cmd_len    <= 8'd0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_d;
      frame_busy <= state_d != S_IDLE;
      pl_wr_en   <= 1'b0;
      cmd_valid  <= 1'b0;
      err_valid  <= 1'b0;
      if (uart_rx_done) begin
        case (state)
          S_IDLE: if (uart_rx_data == SYNC_BYTE) csum <= 8'd0;
          S_CMD: begin
            cmd_sh <= uart_rx_data;
            csum   <= uart_rx_data;
          end
          S_LEN: begin
            if (len_bad) begin
              err_valid <= 1'b1;
              err_code  <= 2'd2;
            end else begin
              len_sh <= uart_rx_data;
              csum   <= csum ^ uart_rx_data;
              idx    <= '0;
            end
          end
          S_PAY: begin
            pl_wr_en   <= 1'b1;
            pl_wr_addr <= idx[ADDR_W-1:0];
            pl_wr_data <= uart_rx_data;
            csum       <= csum ^ uart_rx_data;
            idx        <= idx + 1'b1;
          end
          S_CHK: begin
            if (chk_ok) begin
              cmd_valid <= 1'b1;
              cmd_code  <= cmd_sh;
              cmd_len   <= len_sh;
            end else begin
              err_valid <= 1'b1;
              err_code  <= 2'd1;
            end
          end
          default: ;
        endcase
      end else if (tmo_hit) begin
        err_valid <= 1'b1;
        err_code  <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames for uart_cmd_parser.
// The reference model builds each frame from (cmd, len, payload, good/bad) and
// lists the expected output events. A negedge monitor records the events the
// DUT actually produces.
module tb_uart_cmd_parser;
  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 16;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [7:0]        uart_rx_data = 8'd0;
  logic              uart_rx_done = 1'b0;
  logic              pl_wr_en;
  logic [ADDR_W-1:0] pl_wr_addr;
  logic [7:0]        pl_wr_data;
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic [7:0]        cmd_len;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              frame_busy;

  uart_cmd_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .uart_rx_data(uart_rx_data),
    .uart_rx_done(uart_rx_done), .pl_wr_en(pl_wr_en), .pl_wr_addr(pl_wr_addr),
    .pl_wr_data(pl_wr_data), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .err_valid(err_valid), .err_code(err_code),
    .frame_busy(frame_busy)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  logic [31:0] obs[$];
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  m_code = 8'd0, m_len = 8'd0;
  logic [1:0]  m_err = 2'd0;

  // Event word: {type, a, b, 0}. type 1 = write(addr,data), 2 = cmd(code,len), 3 = err(code)
  function automatic logic [31:0] ev(input logic [7:0] t, input logic [7:0] a, input logic [7:0] b);
    return {t, a, b, 8'h00};
  endfunction

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (pl_wr_en)  obs.push_back(ev(8'd1, 8'(pl_wr_addr), pl_wr_data));
      if (cmd_valid) obs.push_back(ev(8'd2, cmd_code, cmd_len));
      if (err_valid) obs.push_back(ev(8'd3, 8'(err_code), 8'd0));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      uart_rx_done = 1'b0;
      uart_rx_data = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk_in);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    idle(gap);
  endtask

  task automatic send_q(input int gap);
    while (tx_q.size() > 0) send(tx_q.pop_front(), gap);
    idle(4);
  endtask

  function automatic logic [7:0] garbage();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hA5);
    return b;
  endfunction

  // Frame-level reference: a LEN above MAX_LEN is rejected right after LEN is
  // received. Otherwise every payload byte is written in order, and the frame is
  // accepted only when CHK equals the XOR of CMD, LEN and the payload.
  function automatic void plan_frame(input logic [7:0] cmd, input logic [7:0] len, input bit bad);
    logic [7:0] x, b;
    tx_q.push_back(8'hA5); tx_q.push_back(cmd); tx_q.push_back(len);
    if (int'(len) > MAX_LEN) begin
      exp_q.push_back(ev(8'd3, 8'd2, 8'd0));
      m_err = 2'd2;
      return;
    end
    x = cmd ^ len;
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      exp_q.push_back(ev(8'd1, 8'(i), b));
      x ^= b;
    end
    if (bad) begin
      tx_q.push_back(x ^ 8'($urandom_range(1, 255)));
      exp_q.push_back(ev(8'd3, 8'd1, 8'd0));
      m_err = 2'd1;
    end else begin
      tx_q.push_back(x);
      exp_q.push_back(ev(8'd2, cmd, len));
      m_code = cmd;
      m_len = len;
    end
  endfunction

  task automatic test_reset();
    idle(3);
    checks++;
    if ({pl_wr_en, pl_wr_addr, pl_wr_data, cmd_valid, cmd_code, cmd_len, err_valid, err_code, frame_busy} !== 34'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {pl_wr_en, pl_wr_addr, pl_wr_data, cmd_valid, cmd_code, cmd_len, err_valid, err_code, frame_busy});
    end
    @(negedge clk_in); rst_in = 1'b0;
    idle(2);
    checks++;
    if ({cmd_code, cmd_len, err_code, frame_busy} !== 19'd0) begin
      failures++;
      $display("FAIL post_reset_state got=%h required=0", {cmd_code, cmd_len, err_code, frame_busy});
    end
  endtask

  task automatic test_directed();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin tx_q = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
                 exp_q = {ev(1, 0, 8'h11), ev(1, 1, 8'h22), ev(2, 8'h10, 8'h02)};
                 m_code = 8'h10; m_len = 8'h02; end
        1: begin tx_q = {8'hA5, 8'h33, 8'h00, 8'h33};
                 exp_q = {ev(2, 8'h33, 8'h00)}; m_code = 8'h33; m_len = 8'h00; end
        2: begin tx_q = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
                 exp_q = {ev(1, 0, 8'h11), ev(1, 1, 8'h22), ev(3, 1, 0)}; m_err = 2'd1; end
        3: begin tx_q = {8'hA5, 8'h33, 8'h00, 8'h33};
                 exp_q = {ev(2, 8'h33, 8'h00)}; end
        4: begin tx_q = {8'hA5, 8'h10, 8'h11, 8'h00, 8'hFF};
                 exp_q = {ev(3, 2, 0)}; m_err = 2'd2; end
        default: begin tx_q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h33, 8'h00, 8'h33};
                 exp_q = {ev(2, 8'h33, 8'h00)}; end
      endcase
      send_q(1);
      checks++;
      if (obs.size() != exp_q.size()) begin
        failures++;
        $display("FAIL directed%0d event_count got=%0d required=%0d", s, obs.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL directed%0d event%0d got=%h required=%h", s, i, obs[i], exp_q[i]);
        end
      end
      checks++;
      if ({cmd_code, cmd_len, err_code, frame_busy} !== {m_code, m_len, m_err, 1'b0}) begin
        failures++;
        $display("FAIL directed%0d regs got=%h required=%h", s, {cmd_code, cmd_len, err_code, frame_busy}, {m_code, m_len, m_err, 1'b0});
      end
      obs.delete(); exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic [7:0] len;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) tx_q.push_back(garbage());
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, MAX_LEN));
      plan_frame(8'($urandom), len, $urandom_range(0, 3) == 0);
      if (int'(len) > MAX_LEN) repeat ($urandom_range(0, 2)) tx_q.push_back(garbage());
      send_q($urandom_range(0, 2));
      checks++;
      if (obs.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random%0d event_count got=%0d required=%0d", f, obs.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random%0d event%0d got=%h required=%h", f, i, obs[i], exp_q[i]);
        end
      end
      checks++;
      if ({cmd_code, cmd_len, err_code, frame_busy} !== {m_code, m_len, m_err, 1'b0}) begin
        failures++;
        $display("FAIL random%0d regs got=%h required=%h", f, {cmd_code, cmd_len, err_code, frame_busy}, {m_code, m_len, m_err, 1'b0});
      end
      obs.delete(); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    plan_frame(8'h5E, 8'd16, 1'b0);
    plan_frame(8'h21, 8'd1, 1'b1);
    plan_frame(8'h7C, 8'd0, 1'b0);
    send_q(0);
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b event_count got=%0d required=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b event%0d got=%h required=%h", i, obs[i], exp_q[i]);
      end
    end
    checks++;
    if ({cmd_code, cmd_len, err_code} !== {m_code, m_len, m_err}) begin
      failures++;
      $display("FAIL b2b regs got=%h required=%h", {cmd_code, cmd_len, err_code}, {m_code, m_len, m_err});
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    send(8'hA5, 1); send(8'h10, 1); send(8'h04, 1); send(8'h11, 1); send(8'h22, 1);
    exp_q = {ev(1, 0, 8'h11), ev(1, 1, 8'h22)};
    checks++;
    if (frame_busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_busy got=%b required=1", frame_busy);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({pl_wr_en, pl_wr_addr, pl_wr_data, cmd_valid, cmd_code, cmd_len, err_valid, err_code, frame_busy} !== 34'd0) begin
      failures++;
      $display("FAIL async_reset got=%h required=0", {pl_wr_en, pl_wr_addr, pl_wr_data, cmd_valid, cmd_code, cmd_len, err_valid, err_code, frame_busy});
    end
    @(negedge clk_in); rst_in = 1'b0;
    m_code = 8'd0; m_len = 8'd0; m_err = 2'd0;
    plan_frame(8'h5C, 8'd3, 1'b0);
    send_q(1);
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rst_mid event_count got=%0d required=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rst_mid event%0d got=%h required=%h", i, obs[i], exp_q[i]);
      end
    end
    checks++;
    if ({cmd_code, cmd_len, err_code, frame_busy} !== {m_code, m_len, m_err, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid regs got=%h required=%h", {cmd_code, cmd_len, err_code, frame_busy}, {m_code, m_len, m_err, 1'b0});
    end
    obs.delete(); exp_q.delete();
  endtask

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  task automatic test_timeout();
    send(8'hA5, 1); send(8'h10, 1);
    idle(99);
    checks++;
    if ({err_valid, frame_busy} !== 2'b01) begin
      failures++;
      $display("FAIL tmo_early got=%b required=01", {err_valid, frame_busy});
    end
    idle(1);
    checks++;
    if ({err_valid, err_code, frame_busy} !== 4'b1110) begin
      failures++;
      $display("FAIL tmo_expire got=%b required=1110", {err_valid, err_code, frame_busy});
    end
    exp_q.push_back(ev(3, 3, 0)); m_err = 2'd3;
    // A byte landing exactly on the expiry cycle must be taken instead.
    send(8'hA5, 1); send(8'h10, 1);
    idle(98);
    send(8'h02, 1);
    checks++;
    if ({err_valid, frame_busy} !== 2'b01) begin
      failures++;
      $display("FAIL tmo_byte_wins got=%b required=01", {err_valid, frame_busy});
    end
    send(8'h11, 1); send(8'h22, 1); send(8'h21, 1); idle(4);
    exp_q.push_back(ev(1, 0, 8'h11)); exp_q.push_back(ev(1, 1, 8'h22));
    exp_q.push_back(ev(2, 8'h10, 8'h02)); m_code = 8'h10; m_len = 8'h02;
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL tmo event_count got=%0d required=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL tmo event%0d got=%h required=%h", i, obs[i], exp_q[i]);
      end
    end
    checks++;
    if ({cmd_code, cmd_len, err_code} !== {m_code, m_len, m_err}) begin
      failures++;
      $display("FAIL tmo regs got=%h required=%h", {cmd_code, cmd_len, err_code}, {m_code, m_len, m_err});
    end
    obs.delete(); exp_q.delete();
  endtask
`else
  task automatic test_no_timeout();
    send(8'hA5, 1); send(8'h10, 1);
    idle(150);
    checks++;
    if ({frame_busy, err_valid, 32'(obs.size())} !== {2'b10, 32'd0}) begin
      failures++;
      $display("FAIL wait_forever got=busy%b err%b events%0d required=busy1 err0 events0", frame_busy, err_valid, obs.size());
    end
    send(8'h02, 1); send(8'h11, 1); send(8'h22, 1); send(8'h21, 1); idle(4);
    exp_q = {ev(1, 0, 8'h11), ev(1, 1, 8'h22), ev(2, 8'h10, 8'h02)};
    m_code = 8'h10; m_len = 8'h02;
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL no_tmo event_count got=%0d required=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL no_tmo event%0d got=%h required=%h", i, obs[i], exp_q[i]);
      end
    end
    checks++;
    if ({cmd_code, cmd_len, err_code} !== {m_code, m_len, m_err}) begin
      failures++;
      $display("FAIL no_tmo regs got=%h required=%h", {cmd_code, cmd_len, err_code}, {m_code, m_len, m_err});
    end
    obs.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receive path.
- Consumes its byte stream (data byte plus one-cycle done strobe) and frames it into command packets: SYNC, CMD, LEN, payload[LEN], CHK.
- Streams payload bytes out on a write port (to a register file or RAM).
- Issues one-cycle command-valid or error strobes for the control logic.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, largest legal payload length in bytes (1..2^ADDR_W).
- ADDR_W, 4, payload address width.
- TIMEOUT_CYCLES, 32'd43400, max clk_in cycles between bytes inside a frame (~10 byte times at 50 MHz / 115200). Used only with the optional feature.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- uart_rx_data  input  8  received byte; valid when uart_rx_done=1
- uart_rx_done  input  1  one-cycle byte strobe from receive path
- pl_wr_en  output  1  one-cycle payload write strobe
- pl_wr_addr  output  ADDR_W  payload byte index (0-based)
- pl_wr_data  output  8  payload byte
- cmd_valid  output  1  one-cycle strobe: frame accepted
- cmd_code  output  8  CMD byte of last accepted frame
- cmd_len  output  8  LEN byte of last accepted frame
- err_valid  output  1  one-cycle strobe: frame rejected
- err_code  output  2  1=checksum, 2=length, 3=timeout; holds last error
- frame_busy  output  1  high while not in IDLE

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately.
  - All outputs go to 0; state=IDLE; running checksum=0; byte index=0.
  - Reset mid-frame discards the frame; no strobe is emitted.
- Registers and timing:
  - All outputs are registered.
  - Every strobe asserts the cycle after the uart_rx_done that causes it and lasts exactly 1 cycle.
  - Bytes are processed only on cycles with uart_rx_done=1.
- State machine:
  - IDLE: byte==SYNC_BYTE -> CMD; clear checksum. Any other byte is ignored silently, with no error.
  - CMD: latch the byte into a shadow cmd register; checksum=byte -> LEN.
  - LEN, LEN>MAX_LEN: err_valid, err_code=2 -> IDLE.
  - LEN, LEN==0: latch the shadow len; checksum^=byte -> CHK.
  - LEN, otherwise: latch the shadow len; checksum^=byte; index=0 -> PAYLOAD.
  - PAYLOAD, each byte: pl_wr_en=1, pl_wr_addr=index, pl_wr_data=byte; checksum^=byte; index++. Leave for CHK after the byte with index==LEN-1.
  - CHK, byte==checksum: cmd_valid=1; cmd_code/cmd_len are updated from the shadow registers in the same cycle -> IDLE.
  - CHK, mismatch: err_valid=1, err_code=1; cmd_code/cmd_len unchanged -> IDLE.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes. SYNC_BYTE is excluded.
- Aborted frames: payload bytes already written before an abort are not rolled back. The consumer acts only on cmd_valid.
- Back-to-back frames: SYNC may arrive in the byte immediately after CHK; there are no dead cycles.
- frame_busy: 0 in IDLE, 1 in CMD/LEN/PAYLOAD/CHK. Registered together with the state.
- Payload index counter: ADDR_W+1 bits wide internally, so MAX_LEN=2^ADDR_W does not wrap before the compare.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A 32-bit inter-byte counter runs whenever state!=IDLE.
  - The counter clears on each uart_rx_done.
  - On reaching TIMEOUT_CYCLES: err_valid=1, err_code=3, state -> IDLE.
  - If uart_rx_done and expiry coincide, the byte wins: it is processed normally and the counter clears.
- Undefined:
  - No counter logic exists; the parser waits indefinitely mid-frame.
  - err_code never takes value 3.

Test Plan:
- Good frame A5 10 02 11 22 21 -> pl_wr_en at addr 0 (data 11) and addr 1 (data 22); then cmd_valid=1, cmd_code=10, cmd_len=02, err_valid never set.
- Zero-length frame A5 33 00 33 -> no pl_wr_en; cmd_valid=1, cmd_code=33, cmd_len=00.
- Bad checksum A5 10 02 11 22 20 -> err_valid=1, err_code=1; cmd_code keeps its prior value; next frame A5 33 00 33 is accepted.
- Length error A5 10 11 (LEN=17 > 16) -> err_valid=1, err_code=2, frame_busy=0. Following bytes 00 FF are ignored silently.
- Garbage then frame 00 FF 5A A5 33 00 33 -> exactly one cmd_valid. Reset asserted mid-payload -> all outputs 0 asynchronously, then the next good frame is accepted.
- With UART_CMD_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A5 10 then idle 100 cycles -> err_valid, err_code=3, frame_busy=0. A byte arriving on the expiry cycle is instead accepted, with no error.
